// File: rtl/fifo_ecc_rd_ctrl_pkg.sv
// Shared types and helpers for the ECC FIFO read-side sequencer.
package fifo_ecc_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_e;

  // Counters up to 32 bits wide take their saturation value from a slice of this.
  localparam int CNT_W_MAX = 32;
  localparam logic [CNT_W_MAX-1:0] CNT_MAX_ALL = '1;

  // Width able to hold occ + inflight without overflow.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ecc_obuf.sv
// Small synchronous output buffer that absorbs FIFO read latency.
// clr discards all contents and takes priority over push/pop.
module fifo_ecc_obuf
  import fifo_ecc_rd_ctrl_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [occ_w(DEPTH)-1:0]  occ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = occ_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full buffer is accepted only when the head leaves the same cycle.
  assign do_pop  = pop & (occ != '0);
  assign do_push = push & ((occ < OW'(DEPTH)) | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      occ <= occ + OW'(1);
      else if (!do_push && do_pop) occ <= occ - OW'(1);
    end
  end

endmodule

// File: rtl/fifo_ecc_rd_ctrl.sv
// Read-side sequencer for a 32-bit ECC FIFO: issues reads, buffers landed words, counts ECC events.
// FIFO_ECC_DROP_DBITERR_EN: uncorrectable words are counted but never forwarded.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no new reads; in-flight words still land and are buffered
//  ST_RUN   | read while buffer has room for every outstanding word
//  ST_FLUSH | read FIFO dry and discard everything until nothing is in flight
module fifo_ecc_rd_ctrl
  import fifo_ecc_rd_ctrl_pkg::*;
#(
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int OBUF_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_dout,
  input  logic             fifo_sbiterr,
  input  logic             fifo_dbiterr,
  output logic             fifo_rd_en,
  output logic [DW-1:0]    m_data,
  output logic             m_dbiterr,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sbit_cnt,
  output logic [CNT_W-1:0] dbit_cnt,
  output logic             dbit_irq
);

  localparam int OW = occ_w(OBUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_MAX_ALL[CNT_W-1:0];
`ifdef FIFO_ECC_DROP_DBITERR_EN
  localparam int OB_W = DW;
`else
  localparam int OB_W = DW + 1;
`endif

  rd_state_e   state;
  rd_state_e   state_nxt;
  logic [RD_LAT-1:0] lat_sr;
  logic        land;
  logic [OW-1:0] inflight;
  logic [OW-1:0] occ;
  logic        flush_go;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic [OB_W-1:0] ob_wdata;
  logic [OB_W-1:0] ob_rdata;

  assign flush_go = flush & (state != ST_FLUSH);
  assign land     = lat_sr[RD_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OW'(lat_sr[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_go) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state)
        ST_IDLE:  if (en) state_nxt = ST_RUN;
        ST_RUN:   if (!en) state_nxt = ST_IDLE;
        ST_FLUSH: if (fifo_empty && inflight == '0) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Reads are credited against buffer space up front, so the buffer can never overflow.
  always_comb begin
    fifo_rd_en = 1'b0;
    case (state)
      ST_RUN:   fifo_rd_en = !fifo_empty && ((occ + inflight) < OW'(OBUF_DEPTH));
      ST_FLUSH: fifo_rd_en = !fifo_empty;
      default:  fifo_rd_en = 1'b0;
    endcase
    m_valid = (state != ST_FLUSH) && (occ != '0);
    busy    = (state != ST_IDLE) || (occ != '0) || (inflight != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_sr <= '0;
    end else begin
      lat_sr[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LAT; i++) lat_sr[i] <= lat_sr[i-1];
    end
  end

`ifdef FIFO_ECC_DROP_DBITERR_EN
  assign push_ok   = !fifo_dbiterr;
  assign ob_wdata  = fifo_dout;
  assign m_data    = ob_rdata;
  assign m_dbiterr = 1'b0;
`else
  assign push_ok   = 1'b1;
  assign ob_wdata  = {fifo_dbiterr, fifo_dout};
  assign m_data    = ob_rdata[DW-1:0];
  assign m_dbiterr = ob_rdata[DW];
`endif

  assign push = land & push_ok & !flush_go & (state != ST_FLUSH);
  assign pop  = m_valid & m_ready;

  fifo_ecc_obuf #(
    .W     (OB_W),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clr   (flush_go),
    .wdata (ob_wdata),
    .rdata (ob_rdata),
    .occ   (occ)
  );

  // Error accounting sees every landed word, including those discarded by a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
      dbit_irq <= 1'b0;
    end else begin
      dbit_irq <= land & fifo_dbiterr;
      if (cnt_clr)                                          sbit_cnt <= '0;
      else if (land && fifo_sbiterr && sbit_cnt != CNT_MAX) sbit_cnt <= sbit_cnt + CNT_W'(1);
      if (cnt_clr)                                          dbit_cnt <= '0;
      else if (land && fifo_dbiterr && dbit_cnt != CNT_MAX) dbit_cnt <= dbit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_ecc_rd_ctrl.sv
// Self-checking bench for fifo_ecc_rd_ctrl: FIFO read-port model plus expected-stream scoreboard.
module tb_fifo_ecc_rd_ctrl;

  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef FIFO_ECC_DROP_DBITERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, flush, cnt_clr, fifo_empty;
  logic [DW-1:0]    fifo_dout;
  logic             fifo_sbiterr, fifo_dbiterr;
  logic             fifo_rd_en;
  logic [DW-1:0]    m_data;
  logic             m_dbiterr, m_valid, m_ready, busy, dbit_irq;
  logic [CNT_W-1:0] sbit_cnt, dbit_cnt;

  always #5 clk = ~clk;

  fifo_ecc_rd_ctrl #(
    .DW(DW), .RD_LAT(RD_LAT), .OBUF_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .cnt_clr(cnt_clr),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_sbiterr(fifo_sbiterr),
    .fifo_dbiterr(fifo_dbiterr), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_dbiterr(m_dbiterr), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .dbit_irq(dbit_irq)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          db;
  } word_t;

  word_t fq[$];
  word_t xq[$];
  bit    pv[RD_LAT];
  word_t pw[RD_LAT];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_rd = 0, n_out = 0, irq_hi = 0;
  int first_x = -1, last_x = -1;
  int sbit_model = 0, dbit_model = 0;
  bit rd_cap = 1'b0;
  bit hold_v = 1'b0;
  logic [DW-1:0] hold_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic push_word(input logic [DW-1:0] d, input logic s, input logic db);
    word_t w;
    w.d = d; w.s = s; w.db = db;
    fq.push_back(w);
    if (!(DROP && db)) xq.push_back(w);
    sbit_model += int'(s);
    dbit_model += int'(db);
  endtask

  // Pre-edge sampling, then one clock, then FIFO read-port model update.
  task automatic tick();
    word_t w;
    if (m_valid && m_ready) begin
      if (xq.size() == 0) begin
        chk("extra_word", 1, 0);
      end else begin
        w = xq.pop_front();
        chk("m_data", m_data, w.d);
        chk("m_dbiterr", m_dbiterr, w.db);
      end
      n_out++;
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    if (hold_v) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, hold_d);
    end
    hold_v = m_valid && !m_ready && !flush && rst_n;
    hold_d = m_data;
    rd_cap = fifo_rd_en;
    if (rd_cap) n_rd++;
    if (dbit_irq) irq_hi++;

    @(posedge clk); #1;
    cyc++;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pw[i] = pw[i-1];
    end
    pv[0] = 1'b0;
    if (rd_cap && rst_n) begin
      if (fq.size() == 0) chk("rd_en_when_empty", 1, 0);
      else begin
        pw[0] = fq.pop_front();
        pv[0] = 1'b1;
      end
    end
    if (pv[RD_LAT-1]) begin
      fifo_dout    = pw[RD_LAT-1].d;
      fifo_sbiterr = pw[RD_LAT-1].s;
      fifo_dbiterr = pw[RD_LAT-1].db;
    end else begin
      fifo_dout    = $urandom;
      fifo_sbiterr = 1'($urandom_range(0, 1));
      fifo_dbiterr = 1'($urandom_range(0, 1));
    end
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int k;
    en = 1'b1;
    m_ready = 1'b1;
    for (k = 0; k < 300; k++) begin
      if (xq.size() == 0 && fq.size() == 0) break;
      tick();
    end
    if (k == 300) chk({tag, "_timeout"}, 0, 1);
    repeat (4) tick();
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    sbit_model = 0;
    dbit_model = 0;
    irq_hi = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; cnt_clr = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_dout = '0; fifo_sbiterr = 1'b0; fifo_dbiterr = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pv[i] = 1'b0;
    @(negedge clk);
    repeat (2) tick();
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_dbiterr", m_dbiterr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sbit_cnt", sbit_cnt, 0);
    chk("rst_dbit_cnt", dbit_cnt, 0);
    chk("rst_dbit_irq", dbit_irq, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // In-order, gap-free stream of 1..8
    for (int i = 1; i <= 8; i++) push_word(DW'(i), 1'b0, 1'b0);
    n_out = 0; first_x = -1;
    drain("seq");
    chk("seq_count", n_out, 8);
    chk("seq_no_gaps", last_x - first_x, 7);

    // Back-pressure: buffer fills to depth, reads stop, nothing lost
    m_ready = 1'b0;
    n_rd = 0; n_out = 0;
    for (int i = 0; i < 8; i++) push_word($urandom, 1'b0, 1'b0);
    repeat (20) tick();
    chk("stall_reads", n_rd, DEPTH);
    chk("stall_rd_en", fifo_rd_en, 0);
    chk("stall_m_valid", m_valid, 1);
    chk("stall_fifo_left", fq.size(), 8 - DEPTH);
    drain("stall");
    chk("stall_count", n_out, 8);

    // Corrected error forwarded as normal data
    clr_cnt();
    push_word(32'hFFFF_FFFF, 1'b1, 1'b0);
    drain("sbit");
    chk("sbit_cnt_one", sbit_cnt, 1);
    chk("sbit_no_dbit", dbit_cnt, 0);

    // Uncorrectable error on the 3rd word
    clr_cnt();
    n_out = 0;
    for (int i = 1; i <= 8; i++) push_word(DW'(32'h100 + i), 1'b0, i == 3);
    drain("dbit");
    chk("dbit_cnt_one", dbit_cnt, 1);
    chk("dbit_irq_pulses", irq_hi, 1);
    chk("dbit_out_count", n_out, DROP ? 7 : 8);

    // Flush with 10 queued and downstream stalled
    clr_cnt();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word($urandom, (i % 3) == 0, 1'b0);
    repeat (12) tick();
    chk("pre_flush_valid", m_valid, 1);
    en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    xq.delete();
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      chk("flush_m_valid", m_valid, 0);
      tick();
    end
    chk("flush_busy", busy, 0);
    chk("flush_m_valid_end", m_valid, 0);
    chk("flush_fifo_empty", fq.size(), 0);
    chk("flush_sbit_cnt", sbit_cnt, sat(sbit_model));
    n_out = 0;
    for (int i = 0; i < 3; i++) push_word(DW'(32'hA0 + i), 1'b0, 1'b0);
    drain("post_flush");
    chk("post_flush_count", n_out, 3);

    // Saturation and clear
    clr_cnt();
    for (int i = 0; i < 20; i++) push_word($urandom, 1'b1, 1'b0);
    drain("sat");
    chk("sat_sbit_cnt", sbit_cnt, sat(sbit_model));
    chk("sat_dbit_cnt", dbit_cnt, 0);
    clr_cnt();
    tick();
    chk("clr_sbit_cnt", sbit_cnt, 0);

    // Clear held across error words: clear wins every cycle
    cnt_clr = 1'b1;
    for (int i = 0; i < 5; i++) push_word($urandom, 1'b1, 1'b1);
    drain("clr_win");
    chk("clr_win_sbit", sbit_cnt, 0);
    chk("clr_win_dbit", dbit_cnt, 0);
    cnt_clr = 1'b0;
    tick();

    // Randomized traffic with toggling en/m_ready and random error flags
    clr_cnt();
    for (int c = 0; c < 150; c++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 16)
        push_word($urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      m_ready = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      tick();
    end
    drain("rand");
    chk("rand_all_out", xq.size(), 0);
    chk("rand_sbit_cnt", sbit_cnt, sat(sbit_model));
    chk("rand_dbit_cnt", dbit_cnt, sat(dbit_model));
    chk("rand_irq", irq_hi, dbit_model);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
